game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level game controller that drives the Brain physics engine. It owns the game state machine (IDLE/RUN/DEAD) and divides the system clock into game ticks. On each tick it scrolls and refills the 16-cell obstacle map and forwards edge-detected jump requests. It stops the game when the engine reports a collision and keeps the score.

Parameters:
TICK_DIV, 4, clk cycles per game tick (≥2; real builds use large values).
SCORE_W, 8, score counter width.
LFSR_SEED, 16'hACE1, obstacle LFSR reset/restart value (0 illegal).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  start/restart button level (pre-synchronized)
jump_btn  input  1  jump button level (pre-synchronized)
eng_dead  input  1  engine collision flag (is_dead)
eng_jump  input  1  engine airborne flag (jumpout)
eng_start  output  1  engine enable; high iff state==RUN
eng_jump_req  output  1  one-cycle jump pulse to engine (jumpin)
map  output  16  obstacle map; bit15 = player cell, bit0 = entry cell
tick  output  1  one-cycle game-tick strobe
state  output  2  IDLE=0, RUN=1, DEAD=2
score  output  SCORE_W  obstacles cleared
game_over  output  1  high iff state==DEAD

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, map=0, score=0, tick=0, eng_jump_req=0, prescaler=0, jump_pend=0, lfsr=LFSR_SEED, start_q=0, jump_q=0. This has priority over everything, including mid-game.
- start_rise = start & ~start_q. jump_rise = jump_btn & ~jump_q. Both prev registers update every cycle.
- IDLE: outputs held at reset values. On start_rise, go to RUN next cycle. All RUN entries clear map, score, prescaler and jump_pend, and reload lfsr=LFSR_SEED.
- RUN prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1 (combinational from the count, gated by state==RUN). The first tick falls on the TICK_DIV-th RUN cycle.
- On tick (RUN, eng_dead=0):
  - new_bit = lfsr[0] & ~map[0] & ~map[1], using pre-advance values. This guarantees at least 2 empty cells after each obstacle.
  - map <= {map[14:0], new_bit}.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. The LFSR advances only on ticks.
  - If old map[15]==1, score increments, saturating at all-ones.
- Jump handling:
  - jump_rise in RUN sets jump_pend.
  - eng_jump_req = tick & (jump_pend | jump_rise) & ~eng_jump.
  - jump_pend clears on every tick, whether the jump was granted or dropped because the player is airborne.
  - jump_rise in the same cycle as tick is served by that tick.
- Death: eng_dead=1 sampled in RUN → DEAD next cycle. If it coincides with tick, death wins: no map shift, no score change, no jump pulse.
- DEAD: map, score and lfsr frozen; tick=0; eng_start=0. start_rise → RUN (restart with clears as above). eng_dead is ignored outside RUN.
- start_rise while in RUN is ignored.
- state encoding 3 is unreachable; if entered, go to IDLE next cycle.

Decomposition:
- Package game_pkg: state encodings (ST_IDLE/ST_RUN/ST_DEAD), MAP_W=16, LFSR tap constants.
- Sub-module obstacle_gen holds the LFSR plus the new_bit spacing rule. Its ports are clk, rst, load (restart), adv (tick), map_lo[1:0] and new_bit.
- Everything else (FSM, prescaler, map register, score, jump logic) stays in game_sequencer.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, start=0 → state=0, map=0, score=0, tick never asserts over 20 cycles.
2. Start and scroll (TICK_DIV=4): start rises → state=1 next cycle; tick every 4th cycle. Maps after ticks 1–4 are 0x0001, 0x0002, 0x0004, 0x0009.
3. Scoring: eng_dead=0, run 17 ticks → the obstacle inserted at tick 1 leaves bit15 at tick 17, and score=1 after tick 17.
4. Jump: jump_btn rises mid-interval with eng_jump=0 → eng_jump_req=1 exactly in the next tick cycle. Repeat with eng_jump=1 → no pulse, and jump_pend is cleared.
5. Death on tick: assert eng_dead in a tick cycle → state=2 next cycle, map and score unchanged, game_over=1. Then start rises → state=1, map=0, score=0, sequence repeats 0x0001…
6. Reset mid-RUN and score saturation: rst during RUN → IDLE, map=0 next cycle. With SCORE_W=2, the 4th cleared obstacle leaves score at 3.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer slice: FSM state encodings,
// obstacle map width and the obstacle LFSR polynomial.
package game_pkg;

  localparam int unsigned MAP_W = 16;

  // Feedback taps of the 16-bit Fibonacci LFSR: bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  // One LFSR step: shift left, new bit0 is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bus between the game sequencer and its environment (buttons + physics engine).
//   start, jump_btn      : button levels, pre-synchronized
//   eng_dead, eng_jump   : engine collision / airborne flags
//   eng_start            : engine enable (state==RUN)
//   eng_jump_req         : one-cycle jump pulse to the engine
//   map                  : obstacle map, bit15 = player cell, bit0 = entry cell
//   tick                 : one-cycle game-tick strobe
//   state, score         : FSM state and obstacles cleared
//   game_over            : state==DEAD
// master = environment side, slave = sequencer side.
interface game_sequencer_if #(
  parameter int unsigned SCORE_W = 8
);
  import game_pkg::*;

  logic               start;
  logic               jump_btn;
  logic               eng_dead;
  logic               eng_jump;
  logic               eng_start;
  logic               eng_jump_req;
  logic [MAP_W-1:0]   map;
  logic               tick;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  modport master (
    output start, jump_btn, eng_dead, eng_jump,
    input  eng_start, eng_jump_req, map, tick, state, score, game_over
  );

  modport slave (
    input  start, jump_btn, eng_dead, eng_jump,
    output eng_start, eng_jump_req, map, tick, state, score, game_over
  );

endinterface

// File: rtl/obstacle_gen.sv
// Obstacle source: 16-bit LFSR plus the spacing rule that keeps at least two
// empty cells behind every obstacle.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart, reloads the seed
//   adv      : game tick, advances the LFSR
//   map_lo   : current map[1:0]
//   new_bit  : obstacle to insert at the entry cell on this tick
module obstacle_gen
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  input  logic [1:0] map_lo,
  output logic       new_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_lfsr <= LFSR_SEED;
    end else if (adv) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign new_bit = r_lfsr[0] & ~map_lo[0] & ~map_lo[1];

endmodule

// File: rtl/game_sequencer.sv
// Game controller for the physics engine: IDLE/RUN/DEAD state machine,
// game-tick prescaler, scrolling obstacle map, score keeping and
// edge-detected jump forwarding.
//   clk, rst : clock, synchronous active-high reset
//   bus      : game_sequencer_if slave (buttons, engine flags, map/score/state)
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic [MAP_W-1:0]   r_map;
  logic [SCORE_W-1:0] r_score;
  logic               r_jump_pend;
  logic               r_start_q;
  logic               r_jump_q;

  logic w_start_rise;
  logic w_jump_rise;
  logic w_run;
  logic w_tick;
  logic w_enter_run;
  logic w_advance;
  logic w_new_bit;

  assign w_start_rise = bus.start & ~r_start_q;
  assign w_jump_rise  = bus.jump_btn & ~r_jump_q;
  assign w_run        = (r_state == ST_RUN);
  assign w_tick       = w_run && (r_presc == PRESC_MAX);
  assign w_enter_run  = w_start_rise && ((r_state == ST_IDLE) || (r_state == ST_DEAD));
  // A collision reported on a tick cycle wins: the tick scrolls nothing.
  assign w_advance    = w_tick & ~bus.eng_dead;

  obstacle_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_obstacle_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (w_enter_run),
    .adv     (w_advance),
    .map_lo  (r_map[1:0]),
    .new_bit (w_new_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DEAD: if (w_start_rise) w_state_nxt = ST_RUN;
      ST_RUN:           if (bus.eng_dead) w_state_nxt = ST_DEAD;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.eng_start    = w_run;
    bus.game_over    = (r_state == ST_DEAD);
    bus.tick         = w_tick;
    bus.eng_jump_req = w_advance & (r_jump_pend | w_jump_rise) & ~bus.eng_jump;
  end

  assign bus.map   = r_map;
  assign bus.score = r_score;
  assign bus.state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_map       <= '0;
      r_score     <= '0;
      r_jump_pend <= 1'b0;
      r_start_q   <= 1'b0;
      r_jump_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= bus.start;
      r_jump_q  <= bus.jump_btn;
      if (w_enter_run) begin
        r_presc     <= '0;
        r_map       <= '0;
        r_score     <= '0;
        r_jump_pend <= 1'b0;
      end else if (w_run) begin
        r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
        // Every tick consumes the pending request, granted or not.
        if (w_tick) begin
          r_jump_pend <= 1'b0;
        end else if (w_jump_rise) begin
          r_jump_pend <= 1'b1;
        end
        if (w_advance) begin
          r_map <= {r_map[MAP_W-2:0], w_new_bit};
          if (r_map[MAP_W-1] && (r_score != '1)) begin
            r_score <= r_score + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (TICK_DIV=4, SCORE_W=2 so that score
// saturation is reachable). Stimulus pushes the expected tick response
// (jump pulse, map and score after the tick); the monitor pops one entry
// per DUT tick strobe and compares.
module tb_game_sequencer;

  localparam int unsigned SW = 2;

  typedef struct packed {
    logic          jreq;
    logic [15:0]   map;
    logic [SW-1:0] score;
  } exp_t;

  logic clk;
  logic rst;

  game_sequencer_if #(.SCORE_W(SW)) bus ();

  game_sequencer #(
    .TICK_DIV  (4),
    .SCORE_W   (SW),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          q[$];
  logic [15:0]   m_map;
  logic [15:0]   m_lfsr;
  logic [SW-1:0] m_score;
  logic [15:0]   first_maps [4];
  int            n_chk;
  int            n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart();
    m_map   = '0;
    m_lfsr  = 16'hACE1;
    m_score = '0;
  endtask

  task automatic model_tick(input bit jr, input bit dead);
    exp_t e;
    logic nb;
    if (!dead) begin
      nb = m_lfsr[0] & ~m_map[0] & ~m_map[1];
      if (m_map[15] && (m_score != {SW{1'b1}})) m_score = m_score + 1'b1;
      m_map  = {m_map[14:0], nb};
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.jreq  = jr & ~dead;
    e.map   = m_map;
    e.score = m_score;
    q.push_back(e);
  endtask

  // One tick interval starting in the prescaler count-0 cycle; cycle 3 is
  // the tick cycle. jump_at (1..3) pulses jump_btn in that cycle, -1 = none.
  task automatic interval(input int jump_at, input bit ej, input bit dead, input bit poke_start);
    model_tick((jump_at >= 1) && !ej, dead);
    bus.eng_jump = ej;
    for (int c = 0; c < 4; c++) begin
      bus.jump_btn = (c == jump_at);
      if (poke_start) bus.start = (c == 1);
      bus.eng_dead = (c == 3) && dead;
      cyc();
    end
    bus.jump_btn = 1'b0;
    bus.eng_dead = 1'b0;
    bus.eng_jump = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    model_restart();
    check("state_run", bus.state, 2'd1);
    check("eng_start", bus.eng_start, 1'b1);
    check("game_over_run", bus.game_over, 1'b0);
  endtask

  // Monitor: one scoreboard entry per tick strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_tick", bus.tick, 1'b0);
        end else begin
          e = q.pop_front();
          check("jump_req", bus.eng_jump_req, e.jreq);
          @(negedge clk);
          check("map", bus.map, e.map);
          check("score", bus.score, e.score);
        end
      end else if (bus.eng_jump_req === 1'b1) begin
        check("jreq_outside_tick", bus.eng_jump_req, 1'b0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    first_maps[0] = 16'h0001;
    first_maps[1] = 16'h0002;
    first_maps[2] = 16'h0004;
    first_maps[3] = 16'h0009;
    bus.start    = 1'b0;
    bus.jump_btn = 1'b0;
    bus.eng_dead = 1'b0;
    bus.eng_jump = 1'b0;
    model_restart();

    // Reset then idle: no ticks, no pulses, jump ignored.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_state", bus.state, 2'd0);
    check("rst_map", bus.map, 16'h0);
    check("rst_score", bus.score, '0);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_eng_start", bus.eng_start, 1'b0);
    check("rst_game_over", bus.game_over, 1'b0);
    bus.jump_btn = 1'b1;
    cyc();
    bus.jump_btn = 1'b0;
    repeat (19) cyc();
    check("idle_state", bus.state, 2'd0);

    // Start and scroll.
    start_game();
    for (int k = 0; k < 4; k++) begin
      interval(-1, 1'b0, 1'b0, 1'b0);
      check("first_maps", bus.map, first_maps[k]);
    end

    // Jump handling (ticks 5..9).
    interval(2, 1'b0, 1'b0, 1'b0);
    interval(1, 1'b1, 1'b0, 1'b0);
    interval(-1, 1'b0, 1'b0, 1'b0);
    interval(3, 1'b0, 1'b0, 1'b0);
    interval(-1, 1'b0, 1'b0, 1'b1);
    check("start_in_run_ignored", bus.state, 2'd1);

    // Scoring: first obstacle leaves the player cell on tick 17.
    for (int k = 10; k <= 16; k++) interval(-1, 1'b0, 1'b0, 1'b0);
    check("score_tick16", bus.score, '0);
    interval(-1, 1'b0, 1'b0, 1'b0);
    check("score_tick17", bus.score, 2'd1);

    // Obstacles from ticks 4, 7, 11 clear on ticks 20, 23, 27; the last saturates.
    for (int k = 18; k <= 30; k++) interval(-1, 1'b0, 1'b0, 1'b0);
    check("score_saturated", bus.score, 2'd3);

    // Death on a tick with a jump pending: no scroll, no pulse.
    interval(2, 1'b0, 1'b1, 1'b0);
    check("dead_state", bus.state, 2'd2);
    check("dead_game_over", bus.game_over, 1'b1);
    check("dead_eng_start", bus.eng_start, 1'b0);
    bus.eng_dead = 1'b1;
    repeat (6) cyc();
    bus.eng_dead = 1'b0;
    check("dead_hold", bus.state, 2'd2);
    check("dead_score_frozen", bus.score, 2'd3);

    // Restart from DEAD: same sequence as the first game.
    start_game();
    check("restart_map", bus.map, 16'h0);
    check("restart_score", bus.score, '0);
    for (int k = 0; k < 4; k++) begin
      interval(-1, 1'b0, 1'b0, 1'b0);
      check("restart_maps", bus.map, first_maps[k]);
    end

    // Reset mid-RUN.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_state", bus.state, 2'd0);
    check("midrst_map", bus.map, 16'h0);
    check("midrst_score", bus.score, '0);
    repeat (8) cyc();

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
